// File: rtl/pixel_pkg.sv
// Shared types and helpers for the pixel frame sequencer: state encoding,
// phase-control bundle and the output decode applied to the next state.
package pixel_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERASE   = 3'd1,
    S_GAP_E   = 3'd2,
    S_EXPOSE  = 3'd3,
    S_GAP_X   = 3'd4,
    S_CONVERT = 3'd5,
    S_GAP_C   = 3'd6,
    S_READ    = 3'd7
  } seq_state_t;

  typedef struct packed {
    logic busy;
    logic power_enable;
    logic erase;
    logic expose;
    logic convert;
    logic write_enable;
    logic counter_reset;
    logic read;
  } phase_ctrl_t;

  function automatic int num_reads(input int w, input int h, input int p);
    return (w * h) / p;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic phase_ctrl_t phase_decode(input seq_state_t s);
    phase_ctrl_t c;
    c = '0;
    c.busy = (s != S_IDLE);
    unique case (s)
      S_ERASE: c.erase = 1'b1;
      S_EXPOSE: begin
        c.expose       = 1'b1;
        c.power_enable = 1'b1;
        c.write_enable = 1'b1;
      end
      S_CONVERT: begin
        c.convert      = 1'b1;
        c.power_enable = 1'b1;
        c.write_enable = 1'b1;
      end
      S_GAP_C: begin
        c.counter_reset = 1'b1;
        c.power_enable  = 1'b1;
      end
      S_READ: begin
        c.read         = 1'b1;
        c.power_enable = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pixel_frame_sequencer_timer.sv
// pixel_phase_timer: loadable down-counter with terminal-count flag, shared by
// the ERASE, EXPOSE, CONVERT and READ phases.
module pixel_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/pixel_frame_sequencer.sv
// Frame sequencer for the pixel array: erase, expose, convert, read phases.
// Optional PIXEL_SEQ_FRAME_COUNT_EN adds a 16-bit completed-frame counter.
module pixel_frame_sequencer
  import pixel_pkg::*;
#(
  parameter int WIDTH                  = 2,
  parameter int HEIGHT                 = 2,
  parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
  parameter int BIT_DEPTH              = 8,
  parameter int C_ERASE                = 5,
  parameter int EXP_W                  = 8,
  localparam int NUM_READS = num_reads(WIDTH, HEIGHT, OUTPUT_BUS_PIXEL_WIDTH),
  localparam int RA_W      = (NUM_READS > 1) ? $clog2(NUM_READS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 abort,
  input  logic [EXP_W-1:0]     expose_cycles,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 power_enable,
  output logic                 erase,
  output logic                 expose,
  output logic                 convert,
  output logic                 write_enable,
  output logic                 counter_reset,
  output logic                 read,
  output logic [RA_W-1:0]      read_addr,
`ifdef PIXEL_SEQ_FRAME_COUNT_EN
  output logic [15:0]          frame_count,
`endif
  output logic [BIT_DEPTH-1:0] ramp_data
);

  localparam int TW = max_int(max_int(EXP_W, BIT_DEPTH),
                              max_int(max_int($clog2(C_ERASE), $clog2(NUM_READS)), 1));

  seq_state_t           state_q, state_d;
  phase_ctrl_t          ctrl_q, ctrl_d;
  logic [EXP_W-1:0]     exp_q, exp_d;
  logic [BIT_DEPTH-1:0] ramp_q, ramp_d;
  logic [RA_W-1:0]      addr_q, addr_d;
  logic                 done_q, done_d;
  logic                 tmr_load, tmr_tc;
  logic [TW-1:0]        tmr_val;

  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:    if (start) state_d = S_ERASE;
        S_ERASE:   if (tmr_tc) state_d = S_GAP_E;
        S_GAP_E:   state_d = S_EXPOSE;
        S_EXPOSE:  if (tmr_tc) state_d = S_GAP_X;
        S_GAP_X:   state_d = S_CONVERT;
        S_CONVERT: if (tmr_tc) state_d = S_GAP_C;
        S_GAP_C:   state_d = S_READ;
        S_READ:    if (tmr_tc) state_d = continuous ? S_ERASE : S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Every phase transition reloads the timer with (length - 1) of the phase
  // being entered; READ -> ERASE in continuous mode is also a transition.
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    unique case (state_d)
      S_ERASE:   tmr_val = TW'(C_ERASE - 1);
      S_EXPOSE:  tmr_val = TW'(exp_q) - TW'(1);
      S_CONVERT: tmr_val = TW'((2 ** BIT_DEPTH) - 1);
      S_READ:    tmr_val = TW'(NUM_READS - 1);
      default:   tmr_val = '0;
    endcase
  end

  always_comb begin
    exp_d = exp_q;
    if (state_d == S_ERASE && state_q != S_ERASE)
      exp_d = (expose_cycles == '0) ? EXP_W'(1) : expose_cycles;

    ramp_d = '0;
    if (state_d == S_CONVERT && state_q == S_CONVERT)
      ramp_d = ramp_q + BIT_DEPTH'(1);

    addr_d = '0;
    if (state_d == S_READ && state_q == S_READ)
      addr_d = addr_q + RA_W'(1);

    done_d = (state_q == S_READ) && tmr_tc && !abort;
    ctrl_d = phase_decode(state_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      exp_q   <= EXP_W'(1);
      ramp_q  <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      exp_q   <= exp_d;
      ramp_q  <= ramp_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  pixel_phase_timer #(
    .W(TW)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

`ifdef PIXEL_SEQ_FRAME_COUNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    if (done_d)
      fcnt_d = fcnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      fcnt_q <= '0;
    else
      fcnt_q <= fcnt_d;
  end

  assign frame_count = fcnt_q;
`endif

  assign busy          = ctrl_q.busy;
  assign power_enable  = ctrl_q.power_enable;
  assign erase         = ctrl_q.erase;
  assign expose        = ctrl_q.expose;
  assign convert       = ctrl_q.convert;
  assign write_enable  = ctrl_q.write_enable;
  assign counter_reset = ctrl_q.counter_reset;
  assign read          = ctrl_q.read;
  assign read_addr     = addr_q;
  assign ramp_data     = ramp_q;
  assign frame_done    = done_q;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Bench for pixel_frame_sequencer: a small instance (BIT_DEPTH=4, C_ERASE=2)
// and a default instance, checked every cycle against a frame-offset schedule.
module tb_pixel_frame_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, cont0 = 1'b0, abort0 = 1'b0;
  logic [7:0] exp0 = 8'd0;
  logic       busy0, done0, pe0, er0, ex0, cv0, we0, cr0, rd0;
  logic [0:0] ra0;
  logic [3:0] ramp0;

  logic       start1 = 1'b0, cont1 = 1'b0, abort1 = 1'b0;
  logic [7:0] exp1 = 8'd0;
  logic       busy1, done1, pe1, er1, ex1, cv1, we1, cr1, rd1;
  logic [0:0] ra1;
  logic [7:0] ramp1;
`ifdef PIXEL_SEQ_FRAME_COUNT_EN
  logic [15:0] fc0, fc1;
`endif

  pixel_frame_sequencer #(
    .WIDTH(2), .HEIGHT(2), .OUTPUT_BUS_PIXEL_WIDTH(2),
    .BIT_DEPTH(4), .C_ERASE(2), .EXP_W(8)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .continuous(cont0),
    .abort(abort0), .expose_cycles(exp0), .busy(busy0), .frame_done(done0),
    .power_enable(pe0), .erase(er0), .expose(ex0), .convert(cv0),
    .write_enable(we0), .counter_reset(cr0), .read(rd0), .read_addr(ra0),
`ifdef PIXEL_SEQ_FRAME_COUNT_EN
    .frame_count(fc0),
`endif
    .ramp_data(ramp0)
  );

  pixel_frame_sequencer dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .continuous(cont1),
    .abort(abort1), .expose_cycles(exp1), .busy(busy1), .frame_done(done1),
    .power_enable(pe1), .erase(er1), .expose(ex1), .convert(cv1),
    .write_enable(we1), .counter_reset(cr1), .read(rd1), .read_addr(ra1),
`ifdef PIXEL_SEQ_FRAME_COUNT_EN
    .frame_count(fc1),
`endif
    .ramp_data(ramp1)
  );

  typedef struct {
    int busy, pe, er, ex, cv, we, cr, rd, addr, ramp, done;
  } obs_t;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame model: a frame is a run of offsets 0..L-1; each phase is a window.
  function automatic int c_of(input int d);  return (d == 0) ? 2 : 5; endfunction
  function automatic int bd_of(input int d); return (d == 0) ? 4 : 8; endfunction
  function automatic int eff(input int e);   return (e == 0) ? 1 : e; endfunction
  function automatic int flen(input int d, input int e);
    return c_of(d) + e + (1 << bd_of(d)) + 2 + 3;
  endfunction

  function automatic obs_t sched(input int d, input int act, input int off,
                                 input int e, input int done);
    obs_t o;
    int xs, cs, gs, rs;
    o = '{default: 0};
    o.done = done;
    if (act != 0) begin
      o.busy = 1;
      xs = c_of(d) + 1;
      cs = xs + e + 1;
      gs = cs + (1 << bd_of(d));
      rs = gs + 1;
      if (off < c_of(d)) o.er = 1;
      else if (off >= xs && off < xs + e) begin o.ex = 1; o.pe = 1; o.we = 1; end
      else if (off >= cs && off < gs) begin
        o.cv = 1; o.pe = 1; o.we = 1; o.ramp = off - cs;
      end
      else if (off == gs) begin o.cr = 1; o.pe = 1; end
      else if (off >= rs) begin o.rd = 1; o.pe = 1; o.addr = off - rs; end
    end
    return o;
  endfunction

  int m_act[2], m_off[2], m_e[2], m_done[2], m_fc[2];
  initial for (int d = 0; d < 2; d++) begin
    m_act[d] = 0; m_off[d] = 0; m_e[d] = 1; m_done[d] = 0; m_fc[d] = 0;
  end

  function automatic bit in_start(input int d); return (d == 0) ? start0 : start1; endfunction
  function automatic bit in_cont(input int d);  return (d == 0) ? cont0 : cont1;   endfunction
  function automatic bit in_abort(input int d); return (d == 0) ? abort0 : abort1; endfunction
  function automatic int in_exp(input int d);   return (d == 0) ? int'(exp0) : int'(exp1); endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        m_act[d] <= 0; m_off[d] <= 0; m_done[d] <= 0; m_fc[d] <= 0;
      end else if (m_act[d] != 0) begin
        if (in_abort(d)) begin
          m_act[d] <= 0; m_done[d] <= 0;
        end else if (m_off[d] == flen(d, m_e[d]) - 1) begin
          m_done[d] <= 1;
          m_fc[d] <= (m_fc[d] + 1) % 65536;
          if (in_cont(d)) begin
            m_off[d] <= 0; m_e[d] <= eff(in_exp(d));
          end else begin
            m_act[d] <= 0;
          end
        end else begin
          m_off[d] <= m_off[d] + 1; m_done[d] <= 0;
        end
      end else begin
        m_done[d] <= 0;
        if (in_start(d)) begin
          m_act[d] <= 1; m_off[d] <= 0; m_e[d] <= eff(in_exp(d));
        end
      end
    end
  end

  function automatic obs_t get_obs(input int d);
    obs_t o;
    if (d == 0) begin
      o.busy = int'(busy0); o.pe = int'(pe0); o.er = int'(er0); o.ex = int'(ex0);
      o.cv = int'(cv0); o.we = int'(we0); o.cr = int'(cr0); o.rd = int'(rd0);
      o.addr = int'(ra0); o.ramp = int'(ramp0); o.done = int'(done0);
    end else begin
      o.busy = int'(busy1); o.pe = int'(pe1); o.er = int'(er1); o.ex = int'(ex1);
      o.cv = int'(cv1); o.we = int'(we1); o.cr = int'(cr1); o.rd = int'(rd1);
      o.addr = int'(ra1); o.ramp = int'(ramp1); o.done = int'(done1);
    end
    return o;
  endfunction

  task automatic compare_dut(input int d);
    obs_t a, e;
    a = get_obs(d);
    e = reset_n ? sched(d, m_act[d], m_off[d], m_e[d], m_done[d]) : '{default: 0};
    check($sformatf("d%0d.busy", d), a.busy, e.busy);
    check($sformatf("d%0d.power_enable", d), a.pe, e.pe);
    check($sformatf("d%0d.erase", d), a.er, e.er);
    check($sformatf("d%0d.expose", d), a.ex, e.ex);
    check($sformatf("d%0d.convert", d), a.cv, e.cv);
    check($sformatf("d%0d.write_enable", d), a.we, e.we);
    check($sformatf("d%0d.counter_reset", d), a.cr, e.cr);
    check($sformatf("d%0d.read", d), a.rd, e.rd);
    check($sformatf("d%0d.read_addr", d), a.addr, e.addr);
    check($sformatf("d%0d.ramp_data", d), a.ramp, e.ramp);
    check($sformatf("d%0d.frame_done", d), a.done, e.done);
`ifdef PIXEL_SEQ_FRAME_COUNT_EN
    check($sformatf("d%0d.frame_count", d), (d == 0) ? int'(fc0) : int'(fc1),
          reset_n ? m_fc[d] : 0);
`endif
  endtask

  // Activity counters used by the directed checks below.
  int cyc = 0;
  int c_busy = 0, c_er = 0, c_ex = 0, c_cv = 0, c_cr = 0, c_rd = 0, c_done = 0;
  int last_ramp0 = 0;
  int c1_busy = 0, c1_cv = 0, c1_done = 0, last_ramp1 = 0;
  int done_cyc[$];

  always @(negedge clk) begin
    if (chk_en) begin
      compare_dut(0);
      compare_dut(1);
    end
    cyc <= cyc + 1;
    c_busy <= c_busy + int'(busy0);
    c_er   <= c_er + int'(er0);
    c_ex   <= c_ex + int'(ex0);
    c_cv   <= c_cv + int'(cv0);
    c_cr   <= c_cr + int'(cr0);
    c_rd   <= c_rd + int'(rd0);
    c_done <= c_done + int'(done0);
    if (cv0) last_ramp0 <= int'(ramp0);
    if (done0) done_cyc.push_back(cyc);
    c1_busy <= c1_busy + int'(busy1);
    c1_cv   <= c1_cv + int'(cv1);
    c1_done <= c1_done + int'(done1);
    if (cv1) last_ramp1 <= int'(ramp1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_frame0(input int e);
    exp0 = 8'(e);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  task automatic wait_done0(input int base, input int budget);
    for (int i = 0; i < budget && c_done == base; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int b_busy, b_er, b_ex, b_cv, b_cr, b_rd, b_done, n0;
`ifdef PIXEL_SEQ_FRAME_COUNT_EN
  int b_fc;
`endif

  initial begin
    repeat (3) tick();
    chk_en = 1'b1;
    check("rst.busy0", int'(busy0), 0);
    check("rst.ramp1", int'(ramp1), 0);
    check("rst.done0", int'(done0), 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Single frame, exposure 3.
    b_busy = c_busy; b_er = c_er; b_ex = c_ex; b_cv = c_cv;
    b_cr = c_cr; b_rd = c_rd; b_done = c_done;
    start_frame0(3);
    check("s1.latency_busy", int'(busy0), 1);
    check("s1.latency_erase", int'(er0), 1);
    wait_done0(b_done, 60);
    repeat (3) tick();
    check("s1.busy_len", c_busy - b_busy, 26);
    check("s1.erase_len", c_er - b_er, 2);
    check("s1.expose_len", c_ex - b_ex, 3);
    check("s1.convert_len", c_cv - b_cv, 16);
    check("s1.ramp_last", last_ramp0, 15);
    check("s1.creset_len", c_cr - b_cr, 1);
    check("s1.read_len", c_rd - b_rd, 2);
    check("s1.done_cnt", c_done - b_done, 1);

    // Zero exposure is one cycle; mid-frame exposure change is ignored.
    b_ex = c_ex; b_busy = c_busy; b_done = c_done;
    start_frame0(0);
    wait_done0(b_done, 60);
    repeat (2) tick();
    check("s2.expose0_len", c_ex - b_ex, 1);
    check("s2.busy_len", c_busy - b_busy, 24);
    b_ex = c_ex; b_done = c_done;
    start_frame0(5);
    for (int i = 0; i < 20 && !ex0; i++) tick();
    exp0 = 8'd1;
    wait_done0(b_done, 60);
    repeat (2) tick();
    check("s2.expose_hold", c_ex - b_ex, 5);

    // Continuous capture over three frames.
    b_busy = c_busy; b_done = c_done; n0 = done_cyc.size();
`ifdef PIXEL_SEQ_FRAME_COUNT_EN
    b_fc = int'(fc0);
`endif
    cont0 = 1'b1;
    start_frame0(3);
    for (int i = 0; i < 100 && c_done < b_done + 2; i++) tick();
    cont0 = 1'b0;
    for (int i = 0; i < 60 && c_done < b_done + 3; i++) tick();
    repeat (3) tick();
    check("s3.done_cnt", c_done - b_done, 3);
    check("s3.busy_len", c_busy - b_busy, 78);
    if (done_cyc.size() >= n0 + 3) begin
      check("s3.spacing1", done_cyc[n0 + 1] - done_cyc[n0], 26);
      check("s3.spacing2", done_cyc[n0 + 2] - done_cyc[n0 + 1], 26);
    end
`ifdef PIXEL_SEQ_FRAME_COUNT_EN
    check("s3.frame_count", int'(fc0) - b_fc, 3);
`endif

    // Abort at ramp 7, with an ignored start during the frame.
    b_done = c_done;
`ifdef PIXEL_SEQ_FRAME_COUNT_EN
    b_fc = int'(fc0);
`endif
    start_frame0(3);
    tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 40 && !(cv0 && ramp0 == 4'd7); i++) tick();
    check("s4.ramp_at_abort", int'(ramp0), 7);
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    check("s4.busy_after", int'(busy0), 0);
    check("s4.convert_after", int'(cv0), 0);
    check("s4.ramp_after", int'(ramp0), 0);
    repeat (30) tick();
    check("s4.no_done", c_done - b_done, 0);
`ifdef PIXEL_SEQ_FRAME_COUNT_EN
    check("s4.fc_hold", int'(fc0) - b_fc, 0);
`endif

    // Reset mid-exposure, then a clean frame.
    start_frame0(4);
    for (int i = 0; i < 20 && !ex0; i++) tick();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("s5.async_busy", int'(busy0), 0);
    check("s5.async_expose", int'(ex0), 0);
    check("s5.async_pe", int'(pe0), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    b_busy = c_busy; b_done = c_done;
    start_frame0(3);
    wait_done0(b_done, 60);
    repeat (2) tick();
    check("s5.busy_len", c_busy - b_busy, 26);
    check("s5.done_cnt", c_done - b_done, 1);

    // Default configuration, exposure 255.
    b_busy = c1_busy; b_cv = c1_cv; b_done = c1_done;
    exp1 = 8'd255;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 700 && c1_done == b_done; i++) tick();
    repeat (2) tick();
    check("s6.busy_len", c1_busy - b_busy, 521);
    check("s6.convert_len", c1_cv - b_cv, 256);
    check("s6.ramp_last", last_ramp1, 255);
    check("s6.done_cnt", c1_done - b_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_frame_sequencer.md
# pixel_frame_sequencer

Synthesizable frame sequencer for the digital pixel sensor array. It generates the per-frame control phases in order: erase, expose, convert, read. During convert it drives the digital ramp count onto the pixel data bus, and during read it steps through the output-bus word addresses. It replaces the fixed-duration testbench sequencing with a parametrised block that supports:

- a runtime exposure length,
- a start/busy/done handshake,
- abort,
- continuous capture.

It sits between the system controller and `PIXEL_ARRAY`.

## Interface
Parameters:
- `WIDTH`, 2 — pixel columns.
- `HEIGHT`, 2 — pixel rows.
- `OUTPUT_BUS_PIXEL_WIDTH`, 2 — pixels per read word; must divide `WIDTH*HEIGHT`.
- `BIT_DEPTH`, 8 — ADC resolution; convert lasts `2**BIT_DEPTH` cycles.
- `C_ERASE`, 5 — erase cycles, ≥ 1.
- `EXP_W`, 8 — exposure-length field width.

Ports:
- `clk` in 1 — system clock, all logic on posedge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `start` in 1 — begin a frame; sampled only in IDLE.
- `continuous` in 1 — at frame end, restart instead of returning to IDLE.
- `abort` in 1 — synchronous abort to IDLE.
- `expose_cycles` in `EXP_W` — exposure length, latched at frame start; 0 is treated as 1.
- `busy` out 1 — high in every state except IDLE.
- `frame_done` out 1 — one-cycle pulse after the last read cycle.
- `power_enable`, `erase`, `expose`, `convert`, `write_enable`, `counter_reset`, `read` out 1 each — pixel array controls.
- `read_addr` out `$clog2(NUM_READS)` — current read word; `NUM_READS = WIDTH*HEIGHT/OUTPUT_BUS_PIXEL_WIDTH`.
- `ramp_data` out `BIT_DEPTH` — digital ramp value, driven on the data bus during convert.

## Operation
- States: IDLE, ERASE, GAP_E, EXPOSE, GAP_X, CONVERT, GAP_C, READ.
- All outputs are registered. Outputs are decoded from the next state, so each control is high exactly in the cycles its state occupies.
- IDLE: all controls low.
  - `start=1` → ERASE; `expose_cycles` is latched in the same cycle.
- ERASE: `erase=1` for `C_ERASE` cycles → GAP_E.
- GAP_E, GAP_X, GAP_C: one cycle each; `erase`, `expose`, `convert` and `read` are low.
- EXPOSE: `expose`, `power_enable` and `write_enable` high for the latched number of cycles → GAP_X.
- CONVERT: `convert`, `power_enable` and `write_enable` high for `2**BIT_DEPTH` cycles.
  - `ramp_data` is 0 in the first cycle and increments by 1 each cycle, ending at `2**BIT_DEPTH-1`. It does not wrap.
  - Exits to GAP_C.
- GAP_C: `counter_reset=1`, `power_enable=1`.
- READ: `read=1`, `power_enable=1`, `write_enable=0`, for `NUM_READS` cycles. `read_addr` counts 0 → `NUM_READS-1`.
- End of READ: `frame_done` pulses in the following cycle.
  - `continuous=1` at the last READ cycle → ERASE (the `expose_cycles` input is re-latched).
  - Otherwise → IDLE.
- `ramp_data` and `read_addr` hold 0 outside CONVERT and READ.
- `abort=1` in any non-IDLE state → IDLE next cycle; all controls low; no `frame_done`. `abort` has priority over `start` and over a same-cycle end of READ.
- `start` while busy is ignored. Changes to `expose_cycles` mid-frame have no effect.

## Timing
- Reset (`reset_n=0`): state IDLE; every output 0, including `ramp_data`, `read_addr` and `frame_done`. Deassertion takes effect at the next posedge.
- Start latency: `start` sampled at edge k → `erase` and `busy` high from edge k+1.
- Busy duration: `C_ERASE + E + 2**BIT_DEPTH + NUM_READS + 3` cycles, where E is the latched exposure length (minimum 1). `frame_done` is high in the cycle after the last busy cycle (single-shot mode).
- Continuous mode: `busy` stays high. `frame_done` coincides with the first ERASE cycle of the next frame.
- Reset asserted mid-frame: outputs clear asynchronously and immediately.

## Configuration
- `PIXEL_SEQ_FRAME_COUNT_EN` defined:
  - Adds output `frame_count` [15:0], reset to 0.
  - Increments on each `frame_done` and wraps 0xFFFF → 0.
  - Aborted frames are not counted.
- Undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Shared package `pixel_pkg`:
  - state enum typedef `seq_state_t`;
  - `NUM_READS` helper function;
  - phase-control struct typedef used for output decode.
- One sub-module, `pixel_phase_timer`: a loadable down-counter with terminal-count flag, used for the ERASE, EXPOSE, CONVERT and READ durations. The `ramp_data` and `read_addr` counters remain in the top level.

## Test plan
The first four scenarios use `BIT_DEPTH=4`, `C_ERASE=2`, and `WIDTH=HEIGHT=OUTPUT_BUS_PIXEL_WIDTH=2` (so `NUM_READS=2`).
- Single frame, `expose_cycles=3`, `start` pulsed → `erase` 2 cycles, gap, `expose` 3 cycles, gap, `convert` 16 cycles with `ramp_data` 0..15, `counter_reset` 1 cycle, `read` 2 cycles with `read_addr` 0,1, `frame_done` 1 cycle; `busy` 26 cycles.
- `expose_cycles=0` → `expose` high exactly 1 cycle. `expose_cycles` changed during EXPOSE → length unchanged.
- `continuous=1` over 3 frames → no IDLE cycle between frames; 3 `frame_done` pulses spaced 26 cycles apart; `frame_count=3` when `PIXEL_SEQ_FRAME_COUNT_EN` is defined.
- `abort` during CONVERT at `ramp_data=7` → next cycle all outputs 0, `busy=0`, no `frame_done`, `frame_count` unchanged. `start` during busy → ignored.
- `reset_n` pulled low mid-EXPOSE → all outputs 0 immediately. After release, IDLE; the next `start` runs a full, correct frame.
- Defaults (`BIT_DEPTH=8`, `NUM_READS=2`, `expose_cycles=255`): `convert` lasts 256 cycles and ends at `ramp_data=255`; `busy` lasts 521 cycles.
